// File: rtl/pd_match_controller.sv
// pd_match_controller: runs one iterated Prisoner's Dilemma match between two player blocks.
// Each round requests a move from both players, collects both action bits, and forces a
// defect on timeout. It then scores the round with saturation and broadcasts the outcome.
module pd_match_controller #(
    parameter int unsigned ROUNDS  = 200,
    parameter int unsigned SCORE_W = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned PAY_T   = 5,
    parameter int unsigned PAY_R   = 3,
    parameter int unsigned PAY_P   = 1,
    parameter int unsigned PAY_S   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    output logic                        step_req,
    input  logic                        act_valid_A,
    input  logic                        act_valid_B,
    input  logic                        act_A,
    input  logic                        act_B,
    output logic                        fb_valid,
    output logic                        fb_A,
    output logic                        fb_B,
    output logic [SCORE_W-1:0]          score_A,
    output logic [SCORE_W-1:0]          score_B,
    output logic [$clog2(ROUNDS+1)-1:0] round_cnt,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err
);

    localparam int unsigned CNT_W  = $clog2(ROUNDS + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   LAST_ROUND = CNT_W'(ROUNDS);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] P_T        = SCORE_W'(PAY_T);
    localparam logic [SCORE_W-1:0] P_R        = SCORE_W'(PAY_R);
    localparam logic [SCORE_W-1:0] P_P        = SCORE_W'(PAY_P);
    localparam logic [SCORE_W-1:0] P_S        = SCORE_W'(PAY_S);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StCollect,
        StScore,
        StFb,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [SCORE_W-1:0]  score_a_q, score_a_d;
    logic [SCORE_W-1:0]  score_b_q, score_b_d;
    logic [CNT_W-1:0]    round_q, round_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                got_a_q, got_a_d;
    logic                got_b_q, got_b_d;
    logic                act_a_q, act_a_d;
    logic                act_b_q, act_b_d;
    logic                fb_a_q, fb_a_d;
    logic                fb_b_q, fb_b_d;
    logic                to_err_q, to_err_d;
    logic [SCORE_W-1:0]  pay_a, pay_b;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] p);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + {1'b0, p};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    // Payoff lookup for the latched pair of actions (0 = cooperate, 1 = defect).
    always_comb begin
        pay_a = P_P;
        pay_b = P_P;
        unique case ({act_a_q, act_b_q})
            2'b00: begin pay_a = P_R; pay_b = P_R; end
            2'b01: begin pay_a = P_S; pay_b = P_T; end
            2'b10: begin pay_a = P_T; pay_b = P_S; end
            default: begin pay_a = P_P; pay_b = P_P; end
        endcase
    end

    // Next-state logic: match sequencing, action capture, timeout forfeit and scoring.
    always_comb begin
        state_d   = state_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        round_d   = round_q;
        wait_d    = wait_q;
        got_a_d   = got_a_q;
        got_b_d   = got_b_q;
        act_a_d   = act_a_q;
        act_b_d   = act_b_q;
        fb_a_d    = fb_a_q;
        fb_b_d    = fb_b_q;
        to_err_d  = to_err_q;

        unique case (state_q)
            StIdle, StDone: begin
                // abort beats start; it only has a visible effect out of DONE
                if (abort) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d   = StReq;
                    score_a_d = '0;
                    score_b_d = '0;
                    round_d   = '0;
                    to_err_d  = 1'b0;
                    got_a_d   = 1'b0;
                    got_b_d   = 1'b0;
                    act_a_d   = 1'b0;
                    act_b_d   = 1'b0;
                    wait_d    = '0;
                end
            end
            StReq: begin
                state_d = abort ? StIdle : StCollect;
            end
            StCollect: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    // only the first strobe per player per round is kept
                    if (act_valid_A && !got_a_q) begin
                        got_a_d = 1'b1;
                        act_a_d = act_A;
                    end
                    if (act_valid_B && !got_b_q) begin
                        got_b_d = 1'b1;
                        act_b_d = act_B;
                    end
                    wait_d = wait_q + 1'b1;
                    if (got_a_d && got_b_d) begin
                        state_d = StScore;
                    end else if (wait_q == WAIT_LAST) begin
                        // silent player forfeits the round as a defect
                        if (!got_a_d) begin
                            got_a_d = 1'b1;
                            act_a_d = 1'b1;
                        end
                        if (!got_b_d) begin
                            got_b_d = 1'b1;
                            act_b_d = 1'b1;
                        end
                        to_err_d = 1'b1;
                        state_d  = StScore;
                    end
                end
            end
            StScore: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    score_a_d = sat_add(score_a_q, pay_a);
                    score_b_d = sat_add(score_b_q, pay_b);
                    round_d   = round_q + 1'b1;
                    // each player is told what its opponent played
                    fb_a_d    = act_b_q;
                    fb_b_d    = act_a_q;
                    state_d   = StFb;
                end
            end
            StFb: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (round_q == LAST_ROUND) begin
                    state_d = StDone;
                end else begin
                    state_d = StReq;
                    got_a_d = 1'b0;
                    got_b_d = 1'b0;
                    act_a_d = 1'b0;
                    act_b_d = 1'b0;
                    wait_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            score_a_q <= '0;
            score_b_q <= '0;
            round_q   <= '0;
            wait_q    <= '0;
            got_a_q   <= 1'b0;
            got_b_q   <= 1'b0;
            act_a_q   <= 1'b0;
            act_b_q   <= 1'b0;
            fb_a_q    <= 1'b0;
            fb_b_q    <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            round_q   <= round_d;
            wait_q    <= wait_d;
            got_a_q   <= got_a_d;
            got_b_q   <= got_b_d;
            act_a_q   <= act_a_d;
            act_b_q   <= act_b_d;
            fb_a_q    <= fb_a_d;
            fb_b_q    <= fb_b_d;
            to_err_q  <= to_err_d;
        end
    end

    // Status and strobe outputs decoded from the state register.
    always_comb begin
        step_req    = (state_q == StReq);
        fb_valid    = (state_q == StFb);
        busy        = (state_q != StIdle) && (state_q != StDone);
        done        = (state_q == StDone);
        fb_A        = fb_a_q;
        fb_B        = fb_b_q;
        score_A     = score_a_q;
        score_B     = score_b_q;
        round_cnt   = round_q;
        timeout_err = to_err_q;
    end

endmodule

// File: tb/tb_pd_match_controller.sv
// Self-checking bench for pd_match_controller: directed scenarios plus randomized rounds
// checked against a round-level behavioural model of the match.
module tb_pd_match_controller;

    localparam int TO  = 16;
    localparam int RND = 4;
    localparam longint MAXS = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic        act_valid_A, act_valid_B, act_A, act_B;
    logic        step_req, fb_valid, fb_A, fb_B, busy, done, timeout_err;
    logic [31:0] score_A, score_B;
    logic [2:0]  round_cnt;

    // Second instance for the narrow-accumulator saturation scenario.
    logic        s_start, s_abort, s_av, s_act_A, s_act_B;
    logic        s_step_req, s_fb_valid, s_fb_A, s_fb_B, s_busy, s_done, s_to;
    logic [3:0]  s_score_A, s_score_B;
    logic [3:0]  s_round;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state for the current match.
    longint exp_sa, exp_sb;
    int     exp_rc;
    bit     exp_to;
    int     exp_fbk;
    logic   exp_fa, exp_fb;

    pd_match_controller #(.ROUNDS(RND), .SCORE_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .step_req(step_req),
        .act_valid_A(act_valid_A), .act_valid_B(act_valid_B), .act_A(act_A), .act_B(act_B),
        .fb_valid(fb_valid), .fb_A(fb_A), .fb_B(fb_B), .score_A(score_A), .score_B(score_B),
        .round_cnt(round_cnt), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    pd_match_controller #(.ROUNDS(10), .SCORE_W(4), .TIMEOUT(3)) dut_sat (
        .clk(clk), .reset(reset), .start(s_start), .abort(s_abort), .step_req(s_step_req),
        .act_valid_A(s_av), .act_valid_B(s_av), .act_A(s_act_A), .act_B(s_act_B),
        .fb_valid(s_fb_valid), .fb_A(s_fb_A), .fb_B(s_fb_B), .score_A(s_score_A),
        .score_B(s_score_B), .round_cnt(s_round), .busy(s_busy), .done(s_done),
        .timeout_err(s_to)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pay(input logic me, input logic opp);
        if (!me && !opp) return 3;
        if (!me && opp)  return 0;
        if (me && !opp)  return 5;
        return 1;
    endfunction

    task automatic model_start;
        exp_sa = 0; exp_sb = 0; exp_rc = 0; exp_to = 0;
    endtask

    // One round at the level of "who answered when and with what".
    task automatic model_round(input int da, input int db, input logic aa, input logic ab);
        logic ea, eb;
        int   last;
        ea = (da <= TO) ? aa : 1'b1;
        eb = (db <= TO) ? ab : 1'b1;
        if (da > TO || db > TO) exp_to = 1;
        exp_sa = exp_sa + pay(ea, eb);
        exp_sb = exp_sb + pay(eb, ea);
        if (exp_sa > MAXS) exp_sa = MAXS;
        if (exp_sb > MAXS) exp_sb = MAXS;
        exp_rc++;
        last = (da > db) ? da : db;
        if (last > TO) last = TO;
        exp_fbk = last + 2;
        exp_fa  = eb;
        exp_fb  = ea;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Drives one round: player X strobes dX cycles after step_req. Returns the cycle of
    // step_req, the offset k of fb_valid (-1 if none) and the fed-back bits.
    task automatic play_round(input int da, input int db, input logic aa, input logic ab,
                              input bit dup, input bit poke, output int t_req,
                              output int fbk, output logic fa, output logic fbb);
        int n;
        n = 0; fbk = -1; fa = 1'bx; fbb = 1'bx;
        while (step_req !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        t_req = cyc;
        if (step_req !== 1'b1) return;
        for (int k = 1; k <= TO + 4; k++) begin
            @(negedge clk);
            if (fb_valid === 1'b1) begin
                fbk = k; fa = fb_A; fbb = fb_B;
                break;
            end
            act_valid_A = (k == da) || (dup && k == da + 1);
            act_A       = (dup && k == da + 1) ? ~aa : aa;
            act_valid_B = (k == db);
            act_B       = ab;
            start       = poke && (k == 2);
        end
        act_valid_A = 1'b0; act_valid_B = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({step_req, fb_valid, fb_A, fb_B, busy, done, timeout_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=0000000",
                     {step_req, fb_valid, fb_A, fb_B, busy, done, timeout_err});
        end
        n_checks++;
        if (score_A !== 32'd0 || score_B !== 32'd0 || round_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_counts got=%0d/%0d/%0d want=0/0/0", score_A, score_B, round_cnt);
        end
        reset = 1'b1;
        pulse_start;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL start_busy got=%b want=1", busy);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || step_req !== 1'b0) begin
            n_fail++; $display("FAIL async_reset busy=%b step_req=%b want=0/0", busy, step_req);
        end
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_cooperate;
        int t, prev, k;
        logic fa, fbb;
        prev = -1;
        model_start;
        pulse_start;
        for (int r = 0; r < RND; r++) begin
            play_round(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, t, k, fa, fbb);
            model_round(1, 1, 1'b0, 1'b0);
            n_checks++;
            if (k !== exp_fbk) begin
                n_fail++; $display("FAIL coop_fb_offset r=%0d got=%0d want=%0d", r, k, exp_fbk);
            end
            if (r > 0) begin
                n_checks++;
                if (t - prev !== 4) begin
                    n_fail++; $display("FAIL coop_step_gap r=%0d got=%0d want=4", r, t - prev);
                end
            end
            prev = t;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL coop_done done=%b busy=%b want=1/0", done, busy);
        end
        n_checks++;
        if (score_A !== 32'd12 || score_B !== 32'd12 || round_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL coop_final got=%0d/%0d/%0d want=12/12/4", score_A, score_B, round_cnt);
        end
    endtask

    task automatic test_defect_vs_coop;
        int t, k;
        logic fa, fbb;
        model_start;
        pulse_start;
        for (int r = 0; r < RND; r++) begin
            play_round(1, 1, 1'b1, 1'b0, 1'b0, 1'b0, t, k, fa, fbb);
            model_round(1, 1, 1'b1, 1'b0);
            n_checks++;
            if (fa !== 1'b0 || fbb !== 1'b1) begin
                n_fail++; $display("FAIL dvc_fb r=%0d got fb_A=%b fb_B=%b want 0/1", r, fa, fbb);
            end
        end
        @(negedge clk);
        n_checks++;
        if (score_A !== 32'd20 || score_B !== 32'd0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL dvc_final got=%0d/%0d done=%b want=20/0 done=1", score_A, score_B, done);
        end
    endtask

    task automatic test_staggered;
        int t, k;
        logic fa, fbb;
        model_start;
        pulse_start;
        // A answers first then strobes again with the opposite bit; start poked mid-round
        play_round(1, 5, 1'b0, 1'b1, 1'b1, 1'b1, t, k, fa, fbb);
        model_round(1, 5, 1'b0, 1'b1);
        n_checks++;
        if (k !== 7) begin
            n_fail++; $display("FAIL stag_fb_offset got=%0d want=7", k);
        end
        n_checks++;
        if (score_A !== 32'd0 || score_B !== 32'd5 || round_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL stag_score got=%0d/%0d/%0d want=0/5/1", score_A, score_B, round_cnt);
        end
        n_checks++;
        if (fa !== 1'b1 || fbb !== 1'b0) begin
            n_fail++; $display("FAIL stag_fb got=%b/%b want=1/0", fa, fbb);
        end
        for (int r = 1; r < RND; r++) play_round(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, t, k, fa, fbb);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || score_B !== 32'd14) begin
            n_fail++; $display("FAIL stag_final done=%b score_B=%0d want=1/14", done, score_B);
        end
    endtask

    task automatic test_timeout;
        int t, k;
        logic fa, fbb;
        model_start;
        pulse_start;
        play_round(1, 99, 1'b1, 1'b0, 1'b0, 1'b0, t, k, fa, fbb);
        model_round(1, 99, 1'b1, 1'b0);
        n_checks++;
        if (k !== TO + 2) begin
            n_fail++; $display("FAIL to_fb_offset got=%0d want=%0d", k, TO + 2);
        end
        n_checks++;
        if (score_A !== 32'd1 || score_B !== 32'd1 || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL to_score got=%0d/%0d err=%b want=1/1/1", score_A, score_B, timeout_err);
        end
        for (int r = 1; r < RND; r++) play_round(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, t, k, fa, fbb);
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b1 || done !== 1'b1) begin
            n_fail++; $display("FAIL to_sticky err=%b done=%b want=1/1", timeout_err, done);
        end
        pulse_start;
        n_checks++;
        if (timeout_err !== 1'b0 || score_A !== 32'd0 || round_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL to_clear err=%b score_A=%0d rc=%0d want=0/0/0",
                     timeout_err, score_A, round_cnt);
        end
        for (int r = 0; r < RND; r++) play_round(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, t, k, fa, fbb);
        @(negedge clk);
    endtask

    task automatic test_random;
        int t, k, da, db;
        logic fa, fbb, aa, ab;
        bit dup, poke;
        for (int m = 0; m < 3; m++) begin
            model_start;
            pulse_start;
            for (int r = 0; r < RND; r++) begin
                da   = int'($urandom_range(20, 1));
                db   = int'($urandom_range(20, 1));
                aa   = 1'($urandom_range(1, 0));
                ab   = 1'($urandom_range(1, 0));
                dup  = 1'($urandom_range(1, 0));
                poke = 1'($urandom_range(1, 0));
                play_round(da, db, aa, ab, dup, poke, t, k, fa, fbb);
                model_round(da, db, aa, ab);
                n_checks++;
                if (k !== exp_fbk) begin
                    n_fail++;
                    $display("FAIL rnd_fb_offset m=%0d r=%0d da=%0d db=%0d got=%0d want=%0d",
                             m, r, da, db, k, exp_fbk);
                end
                n_checks++;
                if (fa !== exp_fa || fbb !== exp_fb) begin
                    n_fail++;
                    $display("FAIL rnd_fb m=%0d r=%0d got=%b/%b want=%b/%b",
                             m, r, fa, fbb, exp_fa, exp_fb);
                end
                n_checks++;
                if (score_A !== 32'(exp_sa) || score_B !== 32'(exp_sb)) begin
                    n_fail++;
                    $display("FAIL rnd_score m=%0d r=%0d got=%0d/%0d want=%0d/%0d",
                             m, r, score_A, score_B, exp_sa, exp_sb);
                end
                n_checks++;
                if (round_cnt !== 3'(exp_rc)) begin
                    n_fail++;
                    $display("FAIL rnd_round m=%0d r=%0d got=%0d want=%0d", m, r, round_cnt, exp_rc);
                end
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1 || timeout_err !== exp_to) begin
                n_fail++;
                $display("FAIL rnd_end m=%0d done=%b err=%b want=1/%b", m, done, timeout_err, exp_to);
            end
        end
    endtask

    task automatic test_abort;
        int t, k, n;
        logic fa, fbb;
        pulse_start;
        for (int r = 0; r < 2; r++) play_round(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, t, k, fa, fbb);
        n = 0;
        while (step_req !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        @(negedge clk); abort = 1'b1; start = 1'b1;
        @(negedge clk); abort = 1'b0; start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || round_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL abort_collect busy=%b done=%b rc=%0d want=0/0/2", busy, done, round_cnt);
        end
        n_checks++;
        if (score_A !== 32'd6 || score_B !== 32'd6) begin
            n_fail++; $display("FAIL abort_scores got=%0d/%0d want=6/6", score_A, score_B);
        end
        // abort on the SCORE cycle must drop that round's update
        pulse_start;
        n_checks++;
        if (score_A !== 32'd0 || round_cnt !== 3'd0 || step_req !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear score_A=%0d rc=%0d step=%b want=0/0/1",
                     score_A, round_cnt, step_req);
        end
        @(negedge clk); act_valid_A = 1'b1; act_valid_B = 1'b1; act_A = 1'b1; act_B = 1'b1;
        @(negedge clk); act_valid_A = 1'b0; act_valid_B = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_checks++;
        if (score_A !== 32'd0 || score_B !== 32'd0 || round_cnt !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_score got=%0d/%0d rc=%0d busy=%b want=0/0/0/0",
                     score_A, score_B, round_cnt, busy);
        end
        pulse_start;
        for (int r = 0; r < RND; r++) play_round(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, t, k, fa, fbb);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || score_A !== 32'd12 || round_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL abort_rerun done=%b score_A=%0d rc=%0d want=1/12/4",
                     done, score_A, round_cnt);
        end
        abort = 1'b1; start = 1'b1;
        @(negedge clk); abort = 1'b0; start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || score_A !== 32'd12 || round_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL abort_done done=%b busy=%b score_A=%0d rc=%0d want=0/0/12/4",
                     done, busy, score_A, round_cnt);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || step_req !== 1'b0 || round_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL abort_idle busy=%b step=%b rc=%0d want=0/0/4", busy, step_req, round_cnt);
        end
    endtask

    task automatic test_saturation;
        int n, want;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            n = 0;
            while (s_step_req !== 1'b1 && n < 20) begin
                @(negedge clk); n++;
            end
            n_checks++;
            if (s_step_req !== 1'b1) begin
                n_fail++; $display("FAIL sat_step r=%0d got=0 want=1", r);
                return;
            end
            @(negedge clk); s_av = 1'b1;
            @(negedge clk); s_av = 1'b0;
            @(negedge clk);
            want = (5 * r > 15) ? 15 : 5 * r;
            n_checks++;
            if (s_fb_valid !== 1'b1 || s_score_A !== 4'(want) || s_score_B !== 4'd0) begin
                n_fail++;
                $display("FAIL sat_score r=%0d fbv=%b got=%0d/%0d want=1 %0d/0",
                         r, s_fb_valid, s_score_A, s_score_B, want);
            end
        end
        @(negedge clk);
        n_checks++;
        if (s_done !== 1'b1 || s_round !== 4'd10) begin
            n_fail++; $display("FAIL sat_final done=%b rc=%0d want=1/10", s_done, s_round);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        act_valid_A = 1'b0; act_valid_B = 1'b0; act_A = 1'b0; act_B = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_av = 1'b0; s_act_A = 1'b1; s_act_B = 1'b0;
        test_reset;
        test_all_cooperate;
        test_defect_vs_coop;
        test_staggered;
        test_timeout;
        test_random;
        test_abort;
        test_saturation;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pd_match_controller.md
Name: pd_match_controller

Overview:
- Sequences one iterated Prisoner's Dilemma match between two player strategy blocks, for a fixed number of rounds.
- Each round it requests a move from both players and collects the two action bits, tolerating arrival in different cycles or not at all.
- It then applies the payoff matrix, accumulates both scores and broadcasts the round outcome back to the players.
- It sits between the player_A/player_B strategy blocks and the top level; it replaces free-running play with an explicit request/response schedule.

Parameters:
- ROUNDS, 200, rounds per match (>=1).
- SCORE_W, 32, score accumulator width.
- TIMEOUT, 16, cycles to wait in COLLECT for player actions before forfeit (>=1).
- PAY_T/PAY_R/PAY_P/PAY_S, 5/3/1/0: temptation, reward, punishment and sucker payoffs.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin match; honoured only in IDLE or DONE.
- abort  in  1  terminate match, go to IDLE.
- step_req  out  1  one-cycle pulse asking both players for their next action.
- act_valid_A, act_valid_B  in  1  player action strobe.
- act_A, act_B  in  1  action; 0 = cooperate, 1 = defect.
- fb_valid  out  1  one-cycle outcome pulse.
- fb_A, fb_B  out  1  registered actions of the completed round; each player reads the opponent's bit.
- score_A, score_B  out  SCORE_W  accumulated scores.
- round_cnt  out  $clog2(ROUNDS+1)  completed rounds.
- busy  out  1  high in any state except IDLE/DONE.
- done  out  1  high in DONE.
- timeout_err  out  1  sticky forfeit flag; cleared by start.

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0, including scores, round_cnt, fb_*, timeout_err and internal latches.
- States: IDLE, REQ, COLLECT, SCORE, FB, DONE.
- IDLE/DONE --start--> REQ.
  - Same edge: clear scores, round_cnt, timeout_err, action latches and wait counter.
  - done drops on entering REQ.
- REQ: step_req=1 for exactly this cycle; next state COLLECT. Actions presented during REQ are ignored; players must respond no earlier than the cycle after step_req.
- COLLECT: the first act_valid_X seen latches act_X. Later strobes from the same player in the same round are ignored.
  - Both latched (including both in the same cycle) -> SCORE next edge.
  - Wait counter reaches TIMEOUT cycles in COLLECT with a player unlatched -> that action forced to 1 (defect), timeout_err set, -> SCORE.
- SCORE: add payoffs per the matrix below, saturating at 2^SCORE_W-1 (no wrap); round_cnt += 1; fb_A/fb_B loaded. Next state FB.
  - (0,0): R/R.
  - (0,1): S/T.
  - (1,0): T/S.
  - (1,1): P/P.
- FB: fb_valid=1 for one cycle. If round_cnt==ROUNDS -> DONE, else -> REQ with latches and wait counter cleared.
- Minimum round length is 4 cycles (REQ, COLLECT, SCORE, FB) when players answer in the first COLLECT cycle.
- DONE: done=1. Scores, round_cnt and fb_* hold until the next start.
- Outside FB, fb_A/fb_B hold their last values.
- start while busy: ignored.
- abort: from any busy state -> IDLE next edge.
  - Scores/round_cnt keep their last values; done stays 0.
  - A SCORE update on that edge is suppressed.
  - abort overrides start in the same cycle.
  - abort in IDLE/DONE: no effect, except that abort in DONE moves to IDLE and clears done.
- act_valid_* outside COLLECT: ignored.

Test Plan:
- ROUNDS=4, both players answer act=0 one cycle after each step_req -> 4 step_req pulses 4 cycles apart; final score_A=score_B=12, round_cnt=4, done=1.
- ROUNDS=4, A always 1, B always 0 -> score_A=20, score_B=0; fb_B=1 and fb_A=0 on each fb_valid.
- Staggered responses: A valid 1 cycle after step_req, B valid 5 cycles later (B=1, A=0) -> single score update, A+=0, B+=5; duplicate A strobe in same round ignored.
- B never responds, TIMEOUT=16 -> SCORE entered after 16 COLLECT cycles, B forced defect; with A=1 both +1, timeout_err=1 until next start.
- SCORE_W=4, ROUNDS=10, both defect... use A=1,B=0 -> score_A saturates at 15 from round 4 on (no wrap); score_B=0.
- Abort asserted in COLLECT of round 3 with start also high -> IDLE, round_cnt=2, scores unchanged, done=0; subsequent start clears scores and runs a full match.
